// File: rtl/usr_rx_pkg.sv
// rtl/usr_rx_pkg.sv - shared state encoding for the serial receiver
package usr_rx_pkg;

  // Receiver FSM states; 2'd3 is unreachable and decodes back to S_IDLE
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_STOP  = 2'd2
  } state_e;

endpackage

// File: rtl/usr_rx_shift.sv
// rtl/usr_rx_shift.sv - W-bit bidirectional shift register for the receiver
module usr_rx_shift #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         clear_ni,
  input  logic         en_i,
  input  logic         dir_i,
  input  logic         sin_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sr_q, sr_d;

  // dir=1 enters at bit 0 so the first bit ends up in the MSB; dir=0 enters at the MSB
  always_comb begin
    sr_d = sr_q;
    if (en_i) begin
      if (dir_i) sr_d = {sr_q[W-2:0], sin_i};
      else       sr_d = {sin_i, sr_q[W-1:1]};
    end
  end

  // Shift register storage, cleared asynchronously with the rest of the receiver
  always_ff @(posedge clk_i or negedge clear_ni) begin
    if (!clear_ni) sr_q <= '0;
    else           sr_q <= sr_d;
  end

  assign q_o = sr_q;

endmodule

// File: rtl/usr_rx.sv
// rtl/usr_rx.sv - framed serial-to-parallel receiver with valid/ready output
module usr_rx
  import usr_rx_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = 3
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         msb_first,
  output logic [W-1:0] pout,
  output logic         pout_valid,
  input  logic         pout_ready,
  output logic         frame_err,
  output logic         overrun,
  input  logic         err_clr
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [W-1:0]  pout_q, pout_d;
  logic          pout_valid_q, pout_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic [W-1:0]  sr;
  logic          shift_en;

  // Data bits are only shifted on strobes while inside the frame body
  assign shift_en = sin_valid && (state_q == S_SHIFT);

  usr_rx_shift #(.W(W)) u_shift (
    .clk_i    (clk),
    .clear_ni (clear),
    .en_i     (shift_en),
    .dir_i    (dir_q),
    .sin_i    (sin),
    .q_o      (sr)
  );

  // Next-state: frame sequencing on strobes, output handshake and sticky errors
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    pout_d       = pout_q;
    pout_valid_d = pout_valid_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;

    if (pout_valid_q && pout_ready) pout_valid_d = 1'b0;
    // Clear first so a same-cycle set event below takes priority
    if (err_clr) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end

    if (sin_valid) begin
      case (state_q)
        S_IDLE: begin
          if (!sin) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            dir_d   = msb_first;
          end
        end
        S_SHIFT: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W-1)) state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (sin) begin
            // Output register is free if empty or being drained this same edge
            if (!pout_valid_q || pout_ready) begin
              pout_d       = sr;
              pout_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers; reset discards any partial frame
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dir_q        <= 1'b0;
      pout_q       <= '0;
      pout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      pout_q       <= pout_d;
      pout_valid_q <= pout_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign pout       = pout_q;
  assign pout_valid = pout_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
